// File: rtl/ip_recv.sv
// ip_recv: IPv4 header parser in front of udp_recv on the shared receive byte stream.
// It validates the header as it streams past and gates udp_rx_enable onto the UDP bytes of accepted datagrams.
module ip_recv #(
    parameter bit CHECK_CSUM   = 1'b1,
    parameter bit ACCEPT_BCAST = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_enable,
    input  logic [7:0]  data,
    input  logic [31:0] local_ip,
    output logic        udp_rx_enable,
    output logic [31:0] to_ip,
    output logic [31:0] remote_ip,
    output logic        broadcast,
    output logic [15:0] ip_total_len,
    output logic [15:0] csum_err_count
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;
    state_t r_state, w_nextState;

    logic [15:0] r_byteNo, r_hdrLen, r_csum, r_totalLen, r_errCount;
    logic [7:0]  r_hiByte;
    logic [31:0] r_toIp, r_remoteIp;
    logic        r_broadcast, r_rxWasLow;

    logic [16:0] w_sum17;
    logic [15:0] w_csumNext;
    logic [31:0] w_dstIp;
    logic        w_lastHdr, w_csumOk, w_dstBcast, w_dstOk, w_lenOk, w_headOk, w_startFrame, w_reject;

    // Ones'-complement running sum with the end-around carry folded on every word.
    assign w_sum17      = {1'b0, r_csum} + {1'b0, r_hiByte, data};
    assign w_csumNext   = w_sum17[15:0] + {15'd0, w_sum17[16]};
    assign w_csumOk     = (w_csumNext == 16'hFFFF);
    assign w_lastHdr    = (r_byteNo == r_hdrLen - 16'd1);
    assign w_dstIp      = (r_byteNo == 16'd19) ? {r_toIp[23:0], data} : r_toIp;
    assign w_dstBcast   = (w_dstIp == 32'hFFFF_FFFF);
    assign w_dstOk      = (w_dstIp == local_ip) || (ACCEPT_BCAST && w_dstBcast);
    assign w_lenOk      = (r_totalLen >= r_hdrLen + 16'd8) && (r_totalLen <= 16'd1500);
    assign w_headOk     = (data[7:4] == 4'd4) && (data[3:0] >= 4'd5);
    assign w_startFrame = rx_enable && r_rxWasLow;
    assign w_reject     = ((r_byteNo == 16'd6) && (data[5] || (data[4:0] != 5'd0)))
                       || ((r_byteNo == 16'd7) && (data != 8'd0))
                       || ((r_byteNo == 16'd9) && (data != 8'd17));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A frame only starts on a fresh rx_enable rise, so a reset mid-frame ignores the tail.
    always_comb begin
        w_nextState = r_state;
        if (!rx_enable) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_nextState = (w_startFrame && w_headOk) ? HEADER : DONE;
                HEADER: begin
                    if (w_lastHdr) begin
                        if (CHECK_CSUM && !w_csumOk)   w_nextState = DONE;
                        else if (w_dstOk && w_lenOk)   w_nextState = PAYLOAD;
                        else                           w_nextState = DONE;
                    end else if (w_reject) begin
                        w_nextState = DONE;
                    end
                end
                PAYLOAD: if (r_byteNo == r_totalLen - 16'd1) w_nextState = DONE;
                DONE:    w_nextState = DONE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        udp_rx_enable = rx_enable && (r_state == PAYLOAD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_byteNo    <= 16'd0;
            r_hdrLen    <= 16'd0;
            r_csum      <= 16'd0;
            r_totalLen  <= 16'd0;
            r_errCount  <= 16'd0;
            r_hiByte    <= 8'd0;
            r_toIp      <= 32'd0;
            r_remoteIp  <= 32'd0;
            r_broadcast <= 1'b0;
            r_rxWasLow  <= 1'b0;
        end else begin
            r_rxWasLow <= !rx_enable;
            if (!rx_enable) begin
                r_byteNo <= 16'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_startFrame) begin
                            r_byteNo <= 16'd1;
                            r_hdrLen <= {10'd0, data[3:0], 2'b00};
                            r_csum   <= 16'd0;
                            r_hiByte <= data;
                        end
                    end
                    HEADER: begin
                        r_byteNo <= r_byteNo + 16'd1;
                        if (r_byteNo[0]) r_csum   <= w_csumNext;
                        else             r_hiByte <= data;
                        case (r_byteNo)
                            16'd2:  r_totalLen[15:8] <= data;
                            16'd3:  r_totalLen[7:0]  <= data;
                            16'd12, 16'd13, 16'd14, 16'd15:
                                    r_remoteIp <= {r_remoteIp[23:0], data};
                            16'd16, 16'd17, 16'd18:
                                    r_toIp <= {r_toIp[23:0], data};
                            16'd19: begin
                                r_toIp      <= w_dstIp;
                                r_broadcast <= w_dstBcast;
                            end
                            default: ;
                        endcase
                        if (w_lastHdr && !w_csumOk && (r_errCount != 16'hFFFF)) begin
                            r_errCount <= r_errCount + 16'd1;
                        end
                    end
                    PAYLOAD: r_byteNo <= r_byteNo + 16'd1;
                    default: ;
                endcase
            end
        end
    end

    assign to_ip          = r_toIp;
    assign remote_ip      = r_remoteIp;
    assign broadcast      = r_broadcast;
    assign ip_total_len   = r_totalLen;
    assign csum_err_count = r_errCount;

endmodule

// File: tb/tb_ip_recv.sv
// tb_ip_recv: drives directed and random IPv4 frames into two ip_recv instances (default and relaxed parameters)
// and compares every cycle against a packet-level model of which bytes belong to an accepted UDP datagram.
module tb_ip_recv;

    localparam logic [31:0] LOCAL_IP = 32'hC0A8010A;
    localparam logic [31:0] SRC_IP   = 32'hC0A80101;

    logic        clock = 1'b0;
    logic        reset_n, rx_enable;
    logic [7:0]  data;
    logic [31:0] local_ip;
    logic        udpEn0, bcast0, udpEn1, bcast1;
    logic [31:0] toIp0, remoteIp0, toIp1, remoteIp1;
    logic [15:0] totLen0, errCnt0, totLen1, errCnt1;

    ip_recv dut0 (
        .clock(clock), .reset_n(reset_n), .rx_enable(rx_enable), .data(data), .local_ip(local_ip),
        .udp_rx_enable(udpEn0), .to_ip(toIp0), .remote_ip(remoteIp0), .broadcast(bcast0),
        .ip_total_len(totLen0), .csum_err_count(errCnt0)
    );

    ip_recv #(.CHECK_CSUM(1'b0), .ACCEPT_BCAST(1'b0)) dut1 (
        .clock(clock), .reset_n(reset_n), .rx_enable(rx_enable), .data(data), .local_ip(local_ip),
        .udp_rx_enable(udpEn1), .to_ip(toIp1), .remote_ip(remoteIp1), .broadcast(bcast1),
        .ip_total_len(totLen1), .csum_err_count(errCnt1)
    );

    always #5 clock = ~clock;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0]  frameMem [0:1599];
    int          frameLen;
    logic [31:0] expToIp, expRemoteIp;
    logic        expBcast;
    logic [15:0] expTotLen, expErr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Folded ones'-complement sum of the first nBytes of the current frame.
    function automatic logic [15:0] headerSum(input int nBytes);
        int s = 0;
        for (int i = 0; i < nBytes; i += 2) s = s + int'({frameMem[i], frameMem[i+1]});
        while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
        return 16'(s);
    endfunction

    task automatic checkFields(input string tag);
        checkOutput({tag, ":to0"}, toIp0, expToIp);
        checkOutput({tag, ":to1"}, toIp1, expToIp);
        checkOutput({tag, ":rem0"}, remoteIp0, expRemoteIp);
        checkOutput({tag, ":rem1"}, remoteIp1, expRemoteIp);
        checkOutput({tag, ":bc0"}, {31'd0, bcast0}, {31'd0, expBcast});
        checkOutput({tag, ":bc1"}, {31'd0, bcast1}, {31'd0, expBcast});
        checkOutput({tag, ":len0"}, {16'd0, totLen0}, {16'd0, expTotLen});
        checkOutput({tag, ":len1"}, {16'd0, totLen1}, {16'd0, expTotLen});
        checkOutput({tag, ":err0"}, {16'd0, errCnt0}, {16'd0, expErr});
        checkOutput({tag, ":err1"}, {16'd0, errCnt1}, {16'd0, expErr});
    endtask

    task automatic clearModel();
        expToIp = 32'd0;  expRemoteIp = 32'd0;  expBcast = 1'b0;
        expTotLen = 16'd0;  expErr = 16'd0;
    endtask

    // Lays out a header (checksum filled in, optionally corrupted), options, payload and padding.
    task automatic buildFrame(input int version, input int ihl, input int totalLen, input int proto,
                              input logic [7:0] flags, input logic [7:0] off, input logic [31:0] src,
                              input logic [31:0] dst, input bit corrupt, input int pad);
        int hdrBytes;
        int base;
        logic [15:0] cs;
        hdrBytes = (ihl * 4 < 20) ? 20 : ihl * 4;
        frameMem[0]  = {4'(version), 4'(ihl)};
        frameMem[1]  = 8'd0;
        frameMem[2]  = 8'(totalLen >> 8);
        frameMem[3]  = 8'(totalLen);
        frameMem[4]  = 8'($urandom);
        frameMem[5]  = 8'($urandom);
        frameMem[6]  = flags;
        frameMem[7]  = off;
        frameMem[8]  = 8'd64;
        frameMem[9]  = 8'(proto);
        frameMem[10] = 8'd0;
        frameMem[11] = 8'd0;
        for (int k = 0; k < 4; k++) begin
            frameMem[12+k] = 8'(src >> (24 - 8*k));
            frameMem[16+k] = 8'(dst >> (24 - 8*k));
        end
        for (int k = 20; k < hdrBytes; k++) frameMem[k] = 8'($urandom);
        cs = ~headerSum(hdrBytes);
        frameMem[10] = cs[15:8];
        frameMem[11] = cs[7:0];
        if (corrupt) frameMem[11] = frameMem[11] ^ 8'h5A;
        if (totalLen > 1500)          base = hdrBytes + 8;
        else if (totalLen > hdrBytes) base = totalLen;
        else                          base = hdrBytes;
        frameLen = base + pad;
        for (int k = hdrBytes; k < frameLen; k++) frameMem[k] = 8'($urandom);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ":udp0"}, {31'd0, udpEn0}, 32'd0);
        checkOutput({tag, ":udp1"}, {31'd0, udpEn1}, 32'd0);
        checkFields(tag);
    endtask

    // Sends the current frame; resetAt >= 0 pulses reset_n while that byte is on the bus.
    task automatic applyStimulus(input string name, input int resetAt);
        int version, ihl, hdrLen, total;
        logic [31:0] dst, src;
        bit full, csumOk, lenOk, accept0, accept1, resetHit;
        version = int'(frameMem[0][7:4]);
        ihl     = int'(frameMem[0][3:0]);
        hdrLen  = ihl * 4;
        total   = int'({frameMem[2], frameMem[3]});
        src     = {frameMem[12], frameMem[13], frameMem[14], frameMem[15]};
        dst     = {frameMem[16], frameMem[17], frameMem[18], frameMem[19]};
        full    = (version == 4) && (ihl >= 5) && !frameMem[6][5] && (frameMem[6][4:0] == 5'd0)
               && (frameMem[7] == 8'd0) && (frameMem[9] == 8'd17);
        csumOk  = full && (headerSum(hdrLen) == 16'hFFFF);
        lenOk   = (total >= hdrLen + 8) && (total <= 1500);
        accept0 = full && csumOk && ((dst == LOCAL_IP) || (dst == 32'hFFFF_FFFF)) && lenOk;
        accept1 = full && (dst == LOCAL_IP) && lenOk;
        resetHit = 1'b0;
        for (int i = 0; i < frameLen; i++) begin
            @(negedge clock);
            rx_enable = 1'b1;
            data = frameMem[i];
            if (i == resetAt) begin
                reset_n = 1'b0;
                clearModel();
                #1;
                checkAllZero({name, ":rst"});
                #2 reset_n = 1'b1;
                resetHit = 1'b1;
            end else begin
                #1;
                checkOutput({name, ":udp0"}, {31'd0, udpEn0},
                            {31'd0, accept0 && !resetHit && (i >= hdrLen) && (i < total)});
                checkOutput({name, ":udp1"}, {31'd0, udpEn1},
                            {31'd0, accept1 && !resetHit && (i >= hdrLen) && (i < total)});
            end
        end
        @(negedge clock);
        rx_enable = 1'b0;
        data = 8'd0;
        #1;
        checkOutput({name, ":udpEnd0"}, {31'd0, udpEn0}, 32'd0);
        checkOutput({name, ":udpEnd1"}, {31'd0, udpEn1}, 32'd0);
        if (!resetHit) begin
            if ((version == 4) && (ihl >= 5)) expTotLen = 16'(total);
            if (full) begin
                expRemoteIp = src;
                expToIp = dst;
                expBcast = (dst == 32'hFFFF_FFFF);
                if (!csumOk && (expErr != 16'hFFFF)) expErr = expErr + 16'd1;
            end
        end
        checkFields(name);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        rx_enable = 1'b0;
        data = 8'd0;
        local_ip = LOCAL_IP;
        clearModel();
        repeat (2) @(negedge clock);
        #1;
        checkAllZero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        buildFrame(4, 5, 28, 17, 8'h40, 8'h00, SRC_IP, LOCAL_IP, 1'b0, 0);
        applyStimulus("valid28", -1);
        buildFrame(4, 5, 28, 17, 8'h00, 8'h00, SRC_IP, LOCAL_IP, 1'b1, 0);
        applyStimulus("badCsum", -1);
        buildFrame(4, 6, 40, 17, 8'h00, 8'h00, SRC_IP, LOCAL_IP, 1'b0, 0);
        applyStimulus("ihl6", -1);
        buildFrame(4, 5, 36, 17, 8'h00, 8'h00, SRC_IP, 32'hFFFF_FFFF, 1'b0, 0);
        applyStimulus("bcast", -1);
        buildFrame(4, 5, 28, 17, 8'h00, 8'h00, SRC_IP, 32'hC0A80163, 1'b0, 0);
        applyStimulus("otherDst", -1);
        buildFrame(4, 5, 28, 6, 8'h00, 8'h00, SRC_IP, LOCAL_IP, 1'b0, 0);
        applyStimulus("tcp", -1);
        buildFrame(4, 5, 28, 17, 8'h20, 8'h00, SRC_IP, LOCAL_IP, 1'b0, 0);
        applyStimulus("moreFrag", -1);
        buildFrame(4, 5, 28, 17, 8'h00, 8'h00, SRC_IP, LOCAL_IP, 1'b0, 18);
        applyStimulus("padded46", -1);
        buildFrame(4, 5, 28, 17, 8'h00, 8'h00, SRC_IP, LOCAL_IP, 1'b0, 18);
        applyStimulus("midReset", 10);
        buildFrame(4, 5, 30, 17, 8'h00, 8'h00, 32'h0A000001, LOCAL_IP, 1'b0, 4);
        applyStimulus("afterReset", -1);

        for (int n = 0; n < 150; n++) begin
            int ver, ihl, tot, proto, pad, r;
            logic [7:0] fl, off;
            logic [31:0] dst;
            bit bad;
            ver = ($urandom_range(0, 9) == 0) ? 5 : 4;
            ihl = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 8));
            r = $urandom_range(0, 9);
            if (r == 0)      tot = ihl * 4 + int'($urandom_range(0, 7));
            else if (r == 1) tot = 1501 + int'($urandom_range(0, 20));
            else             tot = ihl * 4 + 8 + int'($urandom_range(0, 40));
            if ($urandom_range(0, 9) == 0) fl = 8'($urandom);
            else                           fl = $urandom_range(0, 1) ? 8'h40 : 8'h00;
            off = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            proto = ($urandom_range(0, 7) == 0) ? 6 : 17;
            r = $urandom_range(0, 4);
            if (r < 3)       dst = LOCAL_IP;
            else if (r == 3) dst = 32'hFFFF_FFFF;
            else             dst = $urandom;
            bad = ($urandom_range(0, 6) == 0);
            pad = $urandom_range(0, 20);
            buildFrame(ver, ihl, tot, proto, fl, off, $urandom, dst, bad, pad);
            applyStimulus("rand", -1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ip_recv.md
Name: ip_recv

Overview:
IPv4 header parser sitting directly upstream of udp_recv on the receive byte stream from the MAC/Ethernet-type stage. Consumes the IP header byte-by-byte, validates it (version, IHL, fragmentation, protocol, header checksum, destination) and captures source and destination addresses. For valid UDP datagrams it asserts udp_rx_enable, aligned so that the first UDP header byte is on data in the same cycle. The data bus is shared; this block does not re-drive it.

Parameters:
CHECK_CSUM, 1, 1 = drop packets whose IP header checksum fails; 0 = ignore the checksum.
ACCEPT_BCAST, 1, 1 = accept destination 255.255.255.255 as well as local_ip.

Ports:
clock  in  1  system clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
rx_enable  in  1  high from IP byte 0 through end of frame (incl. padding/CRC); one byte per clock
data  in  8  received byte, valid while rx_enable
local_ip  in  32  this board's IP address
udp_rx_enable  out  1  high while data carries UDP header/payload bytes of an accepted datagram
to_ip  out  32  destination IP of current packet
remote_ip  out  32  source IP of current packet
broadcast  out  1  destination == 32'hFFFFFFFF
ip_total_len  out  16  IP total-length field of current packet
csum_err_count  out  16  saturating count of checksum-failed headers

Behaviour:
- Reset: udp_rx_enable=0, to_ip=0, remote_ip=0, broadcast=0, ip_total_len=0, csum_err_count=0, state=IDLE, byte_no=0, csum accumulator=0.
- States: IDLE, HEADER, PAYLOAD, DONE. rx_enable low in any state -> IDLE on the next edge. udp_rx_enable = rx_enable & (state==PAYLOAD), so it drops combinationally with rx_enable.
- Byte indexing: byte_no counts the bytes consumed since rx_enable rose; byte 0 is consumed on the first rx_enable cycle (in IDLE).
- IDLE (rx_enable, byte 0): version = data[7:4] and must be 4, IHL = data[3:0] and must be >=5, else -> DONE. hdr_len = IHL*4. Clear the accumulator, load the first high byte, byte_no <= 1, -> HEADER.
- HEADER, by byte_no:
  - bytes 2-3: ip_total_len.
  - byte 6: MF flag (bit5) or fragment offset[12:8] nonzero -> DONE. Byte 7: offset[7:0] nonzero -> DONE.
  - byte 9: protocol must be 17, else -> DONE.
  - bytes 12-15: remote_ip, MSB first.
  - bytes 16-19: to_ip, MSB first. broadcast is set from the full 32-bit value at byte 19.
  - bytes 20..hdr_len-1: options; summed, otherwise ignored.
- Checksum: 16-bit ones'-complement sum over all header words, with end-around carry folded each word.
- Edge consuming byte hdr_len-1: final sum including {prev, data} must equal 16'hFFFF.
  - On failure: csum_err_count increments, saturating at 16'hFFFF. If CHECK_CSUM=1 -> DONE.
  - On pass, go to PAYLOAD when all of these hold: destination == local_ip, or (ACCEPT_BCAST and broadcast); ip_total_len >= hdr_len+8; ip_total_len <= 1500. Otherwise -> DONE.
  - Net effect: udp_rx_enable is high in the cycle where byte hdr_len is on data. Latency is zero relative to data.
- PAYLOAD: byte_no increments each byte. When the byte with index ip_total_len-1 is consumed -> DONE, so Ethernet padding and CRC are never presented to UDP.
- DONE: hold until rx_enable falls.
- to_ip, remote_ip, broadcast and ip_total_len hold their values after the packet until overwritten by the next header. udp_recv samples them during PAYLOAD.
- byte_no is 16 bits. The header path never wraps (hdr_len <= 60). Payload is bounded at 1500.
- Simultaneous events: rx_enable falling on the same edge as the DONE/PAYLOAD transition -> IDLE wins.
- Asynchronous reset mid-packet clears everything. The remainder of that frame is ignored, because IDLE needs a new rx_enable rising edge: IDLE is re-entered only via rx_enable low.

Test Plan:
- Valid UDP, IHL=5, total_len=28, dst=local_ip 192.168.1.10, correct checksum -> udp_rx_enable high for exactly 8 cycles starting at byte 20; remote_ip and to_ip match the header; broadcast=0.
- Same packet with one checksum byte flipped, CHECK_CSUM=1 -> udp_rx_enable never high, csum_err_count=1. With CHECK_CSUM=0 -> accepted, count=1.
- IHL=6 (4 option bytes), total_len=40, valid checksum -> udp_rx_enable rises at byte 24 and lasts 16 cycles.
- dst=255.255.255.255 -> broadcast=1, accepted. dst=192.168.1.99 -> rejected. Protocol=6 -> rejected. MF=1 -> rejected.
- 46-byte padded Ethernet payload with total_len=28 -> udp_rx_enable falls after byte 27 although rx_enable stays high.
- reset_n pulsed low at byte 10 -> all outputs 0 immediately; no udp_rx_enable for the rest of that frame. The next frame is parsed normally.
